axi_burst_read_arbiter: RTL

- Shares one AXI4 read master (AR + R channels) between NUM_REQ on-chip requesters, e.g. VIC fetch, CPU refill and DMA in the C64 FPGA design.
- Accepts burst requests (address + length), grants them round-robin, and issues each as a single INCR burst.
- Routes returning beats to the owning requester.
- Allows one burst outstanding at a time. Reports protocol and response errors through a sticky flag.

---
 rtl/axi_rd_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/axi_burst_read_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and AXI constants for the burst read arbiter.
// The arsize helper turns the data bus width into the AXI size encoding.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] clog2_bytes(input int data_w);
        logic [2:0] r_size;
        r_size = '0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == (data_w / 8)) begin
                r_size = 3'(i);
            end
        end
        return r_size;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after the last grant.
// Produces both a one-hot grant and its index; all zero when disabled or idle.
module rr_arbiter #(
    parameter int  NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        // Offset 1 first so the previous winner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_last_grant) + k) % NUM_REQ;
            if (i_enable && !w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_grant[w_idx]     = 1'b1;
                o_grant_idx        = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/axi_burst_read_arbiter.sv
// Shares one AXI4 read master between NUM_REQ requesters, one INCR burst at a time,
// routing returned beats to the owner and flagging protocol/response errors.
module axi_burst_read_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*8-1:0]      i_req_len,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_rsp_last,
    output logic                      o_rsp_err,
    output logic                      o_busy,
    output logic                      o_error,
    output logic [ADDR_W-1:0]         o_m_axi_araddr,
    output logic [7:0]                o_m_axi_arlen,
    output logic [2:0]                o_m_axi_arsize,
    output logic [1:0]                o_m_axi_arburst,
    output logic                      o_m_axi_arvalid,
    input  logic                      i_m_axi_arready,
    input  logic [DATA_W-1:0]         i_m_axi_rdata,
    input  logic [1:0]                i_m_axi_rresp,
    input  logic                      i_m_axi_rlast,
    input  logic                      i_m_axi_rvalid,
    output logic                      o_m_axi_rready
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              r_state;
    logic [IDX_W-1:0]    r_last_grant;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len;
    logic [8:0]          r_beat_cnt;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_error;

    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_arb_en;
    logic                w_beat;
    logic                w_err;
    logic [NUM_REQ-1:0]  w_owner;

    // Gated by reset so no requester sees an accept that the FSM never latches.
    assign w_arb_en = (r_state == IDLE) && !i_reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant),
        .i_enable     (w_arb_en),
        .o_grant      (w_arb_grant),
        .o_grant_idx  (w_arb_idx)
    );

    assign w_beat  = (r_state == DATA) && i_m_axi_rvalid;
    assign w_owner = NUM_REQ'(1) << r_grant_idx;
    assign w_err   = w_beat && ((i_m_axi_rresp != AXI_RESP_OKAY)
                                || (i_m_axi_rlast && (r_beat_cnt != {1'b0, r_len}))
                                || (r_beat_cnt > {1'b0, r_len}));

    assign o_req_ready     = w_arb_grant;
    assign o_rsp_valid     = w_beat ? w_owner : '0;
    assign o_rsp_data      = w_beat ? i_m_axi_rdata : '0;
    assign o_rsp_last      = w_beat && i_m_axi_rlast;
    assign o_rsp_err       = w_err;
    assign o_busy          = (r_state != IDLE);
    assign o_error         = r_error;
    assign o_m_axi_araddr  = r_addr;
    assign o_m_axi_arlen   = r_len;
    assign o_m_axi_arsize  = clog2_bytes(DATA_W);
    assign o_m_axi_arburst = AXI_BURST_INCR;
    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_rready  = r_rready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_grant_idx  <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (w_err) begin
                r_error <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (|w_arb_grant) begin
                        r_grant_idx <= w_arb_idx;
                        r_addr      <= i_req_addr[w_arb_idx*ADDR_W +: ADDR_W];
                        r_len       <= i_req_len[w_arb_idx*8 +: 8];
                        r_arvalid   <= 1'b1;
                        r_state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (i_m_axi_arready) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    // Beats past a missing rlast keep counting (saturating) so they stay flagged.
                    if (i_m_axi_rvalid) begin
                        if (r_beat_cnt != 9'h1FF) begin
                            r_beat_cnt <= r_beat_cnt + 9'd1;
                        end
                        if (i_m_axi_rlast) begin
                            r_rready     <= 1'b0;
                            r_last_grant <= r_grant_idx;
                            r_state      <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
